mem_access_unit: RTL

- Unified instruction/data memory access unit for the multicycle RV32I core.
- Sits directly downstream of the control FSM.
- Takes a one-cycle access request: fetch when IRWrite is asserted, load/store address when AdSrc is asserted, write when MemWrite is asserted.
- Drives a wait-state-capable req/ack memory bus, and returns aligned, extended load data plus a done pulse the FSM uses to advance.

---
 rtl/mem_access_unit_if.sv | 22 ++
 rtl/mem_access_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - req/ack word memory bus between mem_access_unit (master) and memory (slave)
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-3:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_ack;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV32I fetch/load/store access unit with timeout; MEM_MISALIGN_TRAP_EN traps misaligned accesses
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic              i_is_fetch,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_ready,
    output logic              o_done,
    output logic              o_fault,
    output logic [31:0]       o_rdata,
    mem_access_unit_if.master bus_if
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_sign;
    logic [1:0]        r_off;
    logic              r_ready;
    logic              r_done;
    logic              r_fault;
    logic [31:0]       r_rdata;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [ADDR_W-3:0] r_bus_addr;
    logic [3:0]        r_bus_be;
    logic [31:0]       r_bus_wdata;

    logic              w_word;
    logic              w_half;
    logic              w_byte;
    logic              w_illegal;
    logic              w_trap;
    logic [1:0]        w_off;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_shifted;
    logic [31:0]       w_load;
    logic [CNT_W-1:0]  w_cnt_next;

    // Fetches ignore funct3 and always move a full word.
    assign w_word    = i_is_fetch || (i_funct3[1:0] == 2'b10);
    assign w_half    = !i_is_fetch && (i_funct3[1:0] == 2'b01);
    assign w_byte    = !i_is_fetch && (i_funct3[1:0] == 2'b00);
    assign w_illegal = !i_is_fetch && ((i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11));

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = (w_half && i_addr[0]) || (w_word && (i_addr[1:0] != 2'b00));
    assign w_trap     = w_illegal || w_misalign;
`else
    assign w_trap     = w_illegal;
`endif

    always_comb begin
        w_off   = 2'b00;
        w_be    = 4'b1111;
        w_wdata = i_wdata;
        if (w_byte) begin
            w_off   = i_addr[1:0];
            w_be    = 4'b0001 << i_addr[1:0];
            w_wdata = {4{i_wdata[7:0]}};
        end else if (w_half) begin
            w_off   = {i_addr[1], 1'b0};
            w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_wdata[15:0]}};
        end
    end

    assign w_shifted = bus_if.bus_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load = w_shifted;
        case (r_size)
            2'b00:   w_load = {{24{r_sign & w_shifted[7]}},  w_shifted[7:0]};
            2'b01:   w_load = {{16{r_sign & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    assign w_cnt_next = r_cnt + 1'b1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_sign      <= 1'b0;
            r_off       <= 2'b00;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
            r_rdata     <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        r_we        <= i_we;
                        r_size      <= i_is_fetch ? 2'b10 : i_funct3[1:0];
                        r_sign      <= !i_is_fetch && !i_funct3[2];
                        r_off       <= w_off;
                        r_bus_addr  <= i_addr[ADDR_W-1:2];
                        r_bus_be    <= w_be;
                        r_bus_wdata <= w_wdata;
                        r_ready     <= 1'b0;
                        // Rejected requests skip the bus and report straight away.
                        if (w_trap) begin
                            r_fault <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_RESP;
                        end else begin
                            r_bus_req <= 1'b1;
                            r_bus_we  <= i_we;
                            r_state   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    r_cnt <= w_cnt_next;
                    if (bus_if.bus_ack) begin
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        if (!r_we) begin
                            r_rdata <= w_load;
                        end
                        r_done  <= 1'b1;
                        r_state <= S_RESP;
                    end else if (w_cnt_next == CNT_W'(TIMEOUT)) begin
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_fault   <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_done  <= 1'b0;
                    r_fault <= 1'b0;
                    r_cnt   <= '0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ready          = r_ready;
    assign o_done           = r_done;
    assign o_fault          = r_fault;
    assign o_rdata          = r_rdata;
    assign bus_if.bus_req   = r_bus_req;
    assign bus_if.bus_we    = r_bus_we;
    assign bus_if.bus_addr  = r_bus_addr;
    assign bus_if.bus_be    = r_bus_be;
    assign bus_if.bus_wdata = r_bus_wdata;
endmodule
